mac_accumulator: RTL and testbench
==================================

Name: mac_accumulator

Overview:
- Per-neuron multiply-accumulate stage that sits directly upstream of the sigmoid lookup stage.
- Accepts a streamed vector of 8.8 signed input/weight pairs and adds a bias.
- Produces the 8.8 signed pre-activation sum that drives the sigmoid input, with a one-cycle done pulse that qualifies it.
- One operation per start; result is held until the next start.

Parameters:
- N_INPUTS, 16: beats (input/weight pairs) per operation; legal range 1..256.
- DATA_W, 16: operand and result width, signed 8.8.
- FRAC_W, 8: fractional bits of operands and result.
- ACC_W, 40: internal accumulator width, signed Q24.16; must be at least 2*DATA_W + ceil(log2(N_INPUTS)) + 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begins an operation; ignored unless in IDLE or HOLD.
- bias  in  16  signed 8.8; sampled on the accepted start cycle.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat.
- x_in  in  16  signed 8.8 input activation.
- w_in  in  16  signed 8.8 weight.
- mac_out  out  16  signed 8.8 saturated sum; feeds sigmoid sig_in.
- done  out  1  one-cycle pulse, high in the first cycle mac_out holds the new result; feeds sigmoid done.
- busy  out  1  high from the accepted start until the cycle before done.
- ovf  out  1  set when the result saturated; cleared by the next accepted start.

Behaviour:
- Reset values: in_ready=0, done=0, busy=0, ovf=0, mac_out=0x0000. Internally: state=IDLE, count=0, acc=0, product register valid bit=0.
- Reset asserted mid-operation aborts immediately to these values. No partial result is emitted.
- State IDLE: in_ready=0. On start go to ACCUM, with acc = sign-extended bias << FRAC_W and count = 0.
- State ACCUM: in_ready = (count < N_INPUTS).
  - A beat is accepted when in_valid && in_ready.
  - On acceptance: product register <= signed x_in * w_in (32-bit Q16.16), product valid bit <= 1, count += 1.
  - Otherwise the product valid bit <= 0.
  - Each cycle the product valid bit is set, acc <= acc + sign-extended product.
  - in_valid may drop for any number of cycles; no beat is lost or duplicated.
  - When count reaches N_INPUTS, in_ready drops in the following cycle and state goes to DRAIN.
- State DRAIN: one cycle. The final product is added into acc. Go to OUT.
- State OUT: one cycle.
  - Compute acc >>> FRAC_W (arithmetic shift, truncation toward negative infinity).
  - Saturate to [-32768, 32767]; saturation sets ovf.
  - Register the result into mac_out.
  - Go to HOLD with done=1 for exactly that one cycle.
- State HOLD: mac_out and ovf stable, done=0, busy=0, in_ready=0. start behaves as in IDLE.
- Latency: done is high in the cycle after the 3rd rising edge following the cycle in which the last beat is accepted (accept edge, DRAIN edge, OUT edge).
- busy is 1 in ACCUM, DRAIN and OUT.
- start while busy is ignored. bias is not re-sampled.
- start in the same cycle as reset: reset wins.
- in_valid outside ACCUM is ignored.
- The accumulator never wraps; overflow is handled only at output saturation.
- Total cycles from accepted start to done, with no stalls: N_INPUTS + 3.

Decomposition:
- Shared package nn_fixed_pkg holds:
  - DATA_W and FRAC_W.
  - SAT_MAX = 16'sh7FFF and SAT_MIN = 16'sh8000.
  - The 8.8 constants ONE = 16'h0100 and ZERO.
  - The state encoding IDLE/ACCUM/DRAIN/OUT/HOLD.
- The sigmoid and later layers reuse the same package.
- One sub-module, fx_shift_sat: combinational ACC_W to DATA_W arithmetic shift with saturation and an overflow flag. It is reused by later layer stages.

Test Plan:
- N_INPUTS=4, bias=0x0000, four beats x=0x0100 w=0x0200, in_valid held high -> mac_out=0x0800, ovf=0, done high exactly 7 cycles after start, one cycle wide.
- N_INPUTS=4, bias=0x0080, beats (0x0180,0xFF00),(0,0),(0,0),(0,0) -> 0.5 - 1.5 = -1.0, mac_out=0xFF00.
- N_INPUTS=1, bias=0, x=0x0001 w=0xFF00 -> truncation toward negative infinity, mac_out=0xFFFF; x=0x7F00 w=0x7F00 -> mac_out=0x7FFF, ovf=1; x=0x8000 w=0x7F00 -> mac_out=0x8000, ovf=1.
- N_INPUTS=4, in_valid toggled 1,0,0,1,0,1,1 with distinct values -> exactly 4 beats summed, in_ready drops after the 4th, no extra beat absorbed.
- start pulsed again in the 2nd ACCUM cycle with a different bias -> ignored, result uses the original bias. start in HOLD -> new operation, ovf cleared.
- reset asserted after 2 accepted beats -> next cycle all outputs at reset values, no done. A fresh start then gives a correct result.

Source files
------------

// File: rtl/nn_fixed_pkg.sv
// Fixed-point (8.8 signed) constants and the pipeline-stage state type shared by
// the MAC, the sigmoid lookup and the later layer stages.
package nn_fixed_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

  localparam logic [DATA_W-1:0] ONE  = 16'h0100;
  localparam logic [DATA_W-1:0] ZERO = 16'h0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    DRAIN = 3'd2,
    OUT   = 3'd3,
    HOLD  = 3'd4
  } stage_state_e;

  // Sign-extends an 8.8 value into a wider accumulator aligned to 2*FRAC_W fraction bits.
  function automatic logic [63:0] q88_to_acc64(input logic [DATA_W-1:0] v);
    logic signed [63:0] ext;
    ext = 64'(signed'(v));
    return ext <<< FRAC_W;
  endfunction

endpackage

// File: rtl/fx_shift_sat.sv
// Combinational arithmetic right shift of a wide signed value, saturated into a
// narrower signed result with an overflow flag.
module fx_shift_sat #(
  parameter int IN_W  = 40,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic [IN_W-1:0]  val_i,
  output logic [OUT_W-1:0] res_o,
  output logic             ovf_o
);

  logic signed [IN_W-1:0] shifted;
  logic [IN_W-OUT_W:0]    top_bits;
  logic                   fits;

  always_comb begin
    shifted  = $signed(val_i) >>> SHIFT;
    // The value fits when every bit above the result's sign bit repeats that sign bit.
    top_bits = shifted[IN_W-1:OUT_W-1];
    fits     = (top_bits == '0) || (top_bits == '1);
    res_o    = shifted[OUT_W-1:0];
    ovf_o    = 1'b0;
    if (!fits) begin
      ovf_o = 1'b1;
      res_o = shifted[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                              : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Per-neuron multiply-accumulate: bias + sum(x*w) over N_INPUTS streamed 8.8 beats,
// saturated back to 8.8 and held with a one-cycle done pulse for the sigmoid stage.
module mac_accumulator
  import nn_fixed_pkg::*;
#(
  parameter int N_INPUTS = 16,
  parameter int DATA_W   = nn_fixed_pkg::DATA_W,
  parameter int FRAC_W   = nn_fixed_pkg::FRAC_W,
  parameter int ACC_W    = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] w_in,
  output logic [DATA_W-1:0] mac_out,
  output logic              done,
  output logic              busy,
  output logic              ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

  stage_state_e             state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic signed [PROD_W-1:0] prod_q;
  logic                     prod_vld_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  prod_ext;
  logic                     in_ready_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     ovf_q;
  logic [DATA_W-1:0]        mac_out_q;
  logic                     beat;
  logic [DATA_W-1:0]        sat_res;
  logic                     sat_ovf;

  assign beat     = in_valid && in_ready_q;
  assign bias_ext = {{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};
  assign prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
  assign acc_d    = acc_q + prod_ext;

  fx_shift_sat #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W),
    .SHIFT (FRAC_W)
  ) u_shift_sat (
    .val_i (acc_q),
    .res_o (sat_res),
    .ovf_o (sat_ovf)
  );

  // Product is registered one cycle ahead of accumulation; DRAIN exists only to
  // fold in the product of the final accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      mac_out_q  <= ZERO;
    end else begin
      done_q     <= 1'b0;
      prod_vld_q <= 1'b0;
      if (prod_vld_q) begin
        acc_q <= acc_d;
      end

      case (state_q)
        IDLE, HOLD: begin
          if (start) begin
            state_q    <= ACCUM;
            acc_q      <= bias_ext;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
          end
        end
        ACCUM: begin
          if (beat) begin
            prod_q     <= $signed(x_in) * $signed(w_in);
            prod_vld_q <= 1'b1;
            cnt_q      <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IDX) begin
              in_ready_q <= 1'b0;
              state_q    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          state_q <= OUT;
        end
        OUT: begin
          mac_out_q <= sat_res;
          ovf_q     <= sat_ovf;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= HOLD;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign mac_out  = mac_out_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed and random operations on a
// 4-input and a 1-input instance, checked against an arithmetic reference model.
module tb_mac_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        st, vld;
  logic [15:0] bias_s, xv, wv;

  logic        st4, st1, v4, v1;
  logic        rdy4, rdy1, done4, done1, busy4, busy1, ovf4, ovf1;
  logic [15:0] out4, out1;
  logic        rdy, dn, bsy, ov;
  logic [15:0] mo;

  int total = 0;
  int bad   = 0;

  assign st4 = st  & ~sel;
  assign st1 = st  &  sel;
  assign v4  = vld & ~sel;
  assign v1  = vld &  sel;
  assign rdy = sel ? rdy1  : rdy4;
  assign dn  = sel ? done1 : done4;
  assign bsy = sel ? busy1 : busy4;
  assign ov  = sel ? ovf1  : ovf4;
  assign mo  = sel ? out1  : out4;

  mac_accumulator #(.N_INPUTS(4)) u_dut4 (
    .clk(clk), .reset(rst), .start(st4), .bias(bias_s),
    .in_valid(v4), .in_ready(rdy4), .x_in(xv), .w_in(wv),
    .mac_out(out4), .done(done4), .busy(busy4), .ovf(ovf4)
  );

  mac_accumulator #(.N_INPUTS(1)) u_dut1 (
    .clk(clk), .reset(rst), .start(st1), .bias(bias_s),
    .in_valid(v1), .in_ready(rdy1), .x_in(xv), .w_in(wv),
    .mac_out(out1), .done(done1), .busy(busy1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Real-valued meaning: bias + sum(x*w), floored to 8.8, clamped to the 16-bit range.
  function automatic logic [16:0] ref_result(input logic [15:0] b, input logic [15:0] xs[4],
                                             input logic [15:0] ws[4], input int n);
    longint s;
    longint r;
    logic [63:0] ru;
    s = longint'($signed(b)) * 256;
    for (int i = 0; i < n; i++)
      s += longint'($signed(xs[i])) * longint'($signed(ws[i]));
    r = s >>> 8;
    if (r > 32767)  return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
    ru = 64'(r);
    return {1'b0, ru[15:0]};
  endfunction

  task automatic run_op(input string tag, input int n, input logic [15:0] b,
                        input logic [15:0] xs[4], input logic [15:0] ws[4],
                        input int stall_pct, input logic use_pat, input logic [15:0] pat,
                        input logic restart);
    logic [16:0] expv;
    int          idx, cyc, done_at, last_acc;
    logic        extra_acc, busy_bad, v, ovf_start, rdy_start;
    expv = ref_result(b, xs, ws, n);
    st = 1'b1; bias_s = b; vld = 1'b0;
    @(posedge clk); #1;
    st = 1'b0; bias_s = 16'($urandom);
    idx = 0; cyc = 1; done_at = 0; last_acc = 0;
    extra_acc = 1'b0; busy_bad = 1'b0; ovf_start = 1'b1; rdy_start = 1'b0;
    while (done_at == 0 && cyc < 200) begin
      if (cyc == 1) begin
        ovf_start = ov;
        rdy_start = rdy;
      end
      if (dn) begin
        done_at = cyc;
      end else begin
        if (!bsy) busy_bad = 1'b1;
        st = restart && (cyc == 2);
        if (st) bias_s = b ^ 16'h1357;
        if (use_pat && cyc <= 16) v = pat[cyc-1];
        else if (idx < n)         v = ($urandom_range(99) >= 32'(stall_pct));
        else                      v = 1'b1;
        vld = v;
        if (v && idx < n) begin
          xv = xs[idx]; wv = ws[idx];
        end else begin
          xv = 16'($urandom); wv = 16'($urandom);
        end
        if (v && rdy) begin
          if (idx < n) begin
            idx++;
            last_acc = cyc;
          end else begin
            extra_acc = 1'b1;
          end
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    vld = 1'b0; st = 1'b0;
    chk({tag, "_ovf_cleared_on_start"}, 32'(ovf_start), 32'd0);
    chk({tag, "_ready_after_start"},    32'(rdy_start), 32'd1);
    chk({tag, "_done_seen"},            32'(done_at != 0), 32'd1);
    chk({tag, "_latency"},              32'(done_at), 32'(last_acc + 3));
    if (stall_pct == 0 && !use_pat)
      chk({tag, "_start_to_done"},      32'(done_at), 32'(n + 3));
    chk({tag, "_beats"},                32'(idx), 32'(n));
    chk({tag, "_no_extra_beat"},        32'(extra_acc), 32'd0);
    chk({tag, "_busy_during_op"},       32'(busy_bad), 32'd0);
    chk({tag, "_busy_at_done"},         32'(bsy), 32'd0);
    chk({tag, "_mac_out"},              32'(mo), 32'(expv[15:0]));
    chk({tag, "_ovf"},                  32'(ov), 32'(expv[16]));
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"},       32'(dn), 32'd0);
    chk({tag, "_mac_out_held"},         32'(mo), 32'(expv[15:0]));
  endtask

  initial begin
    logic [15:0] xs[4];
    logic [15:0] ws[4];
    logic        done_seen;
    logic [15:0] rb;

    rst = 1'b1; sel = 1'b0; st = 1'b0; vld = 1'b0;
    bias_s = '0; xv = '0; wv = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      chk("reset_in_ready", 32'(rdy), 32'd0);
      chk("reset_done",     32'(dn),  32'd0);
      chk("reset_busy",     32'(bsy), 32'd0);
      chk("reset_ovf",      32'(ov),  32'd0);
      chk("reset_mac_out",  32'(mo),  32'd0);
    end

    sel = 1'b0;
    xs = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    ws = '{16'h0200, 16'h0200, 16'h0200, 16'h0200};
    run_op("basic4", 4, 16'h0000, xs, ws, 0, 1'b0, 16'h0000, 1'b0);

    xs = '{16'h0180, 16'h0000, 16'h0000, 16'h0000};
    ws = '{16'hFF00, 16'h0000, 16'h0000, 16'h0000};
    run_op("bias_neg", 4, 16'h0080, xs, ws, 0, 1'b0, 16'h0000, 1'b0);

    sel = 1'b1;
    xs = '{16'h0001, 16'h0, 16'h0, 16'h0}; ws = '{16'hFF00, 16'h0, 16'h0, 16'h0};
    run_op("floor1", 1, 16'h0000, xs, ws, 0, 1'b0, 16'h0000, 1'b0);
    xs = '{16'h7F00, 16'h0, 16'h0, 16'h0}; ws = '{16'h7F00, 16'h0, 16'h0, 16'h0};
    run_op("satpos1", 1, 16'h0000, xs, ws, 0, 1'b0, 16'h0000, 1'b0);
    xs = '{16'h8000, 16'h0, 16'h0, 16'h0}; ws = '{16'h7F00, 16'h0, 16'h0, 16'h0};
    run_op("satneg1", 1, 16'h0000, xs, ws, 0, 1'b0, 16'h0000, 1'b0);

    sel = 1'b0;
    xs = '{16'h0100, 16'h0240, 16'hFE80, 16'h0033};
    ws = '{16'h0300, 16'hFF80, 16'h0110, 16'h0500};
    run_op("toggle", 4, 16'h0010, xs, ws, 0, 1'b1, 16'hFFE9, 1'b0);

    xs = '{16'h0050, 16'h0120, 16'hFFA0, 16'h0200};
    ws = '{16'h0400, 16'h0100, 16'h0220, 16'hFF00};
    run_op("restart_ignored", 4, 16'h0300, xs, ws, 0, 1'b0, 16'h0000, 1'b1);

    xs = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
    ws = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
    run_op("sat4", 4, 16'h7FFF, xs, ws, 0, 1'b0, 16'h0000, 1'b0);
    xs = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    ws = '{16'h0100, 16'hFF00, 16'h0080, 16'h0040};
    run_op("hold_restart", 4, 16'hFF00, xs, ws, 20, 1'b0, 16'h0000, 1'b0);

    // Abort after two accepted beats; mac_out and ovf are nonzero beforehand.
    run_op("pre_abort_sat", 4, 16'h7FFF, '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00},
           '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00}, 0, 1'b0, 16'h0000, 1'b0);
    st = 1'b1; bias_s = 16'h1234;
    @(posedge clk); #1;
    st = 1'b0; vld = 1'b1; xv = 16'h0200; wv = 16'h0300;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(rdy), 32'd0);
    chk("abort_done",     32'(dn),  32'd0);
    chk("abort_busy",     32'(bsy), 32'd0);
    chk("abort_ovf",      32'(ov),  32'd0);
    chk("abort_mac_out",  32'(mo),  32'd0);
    done_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (dn) done_seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);

    rst = 1'b1; st = 1'b1; bias_s = 16'h0100;
    @(posedge clk); #1;
    rst = 1'b0; st = 1'b0;
    chk("reset_beats_start_busy",  32'(bsy), 32'd0);
    chk("reset_beats_start_ready", 32'(rdy), 32'd0);

    xs = '{16'h0180, 16'hFFC0, 16'h0020, 16'h0101};
    ws = '{16'h0200, 16'h0300, 16'hF000, 16'h0010};
    run_op("fresh_after_reset", 4, 16'hFFF0, xs, ws, 0, 1'b0, 16'h0000, 1'b0);

    for (int k = 0; k < 24; k++) begin
      sel = k[0];
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(1) == 0) begin
          xs[i] = 16'($urandom); ws[i] = 16'($urandom);
        end else begin
          xs[i] = 16'(signed'(10'($urandom))); ws[i] = 16'(signed'(10'($urandom)));
        end
      end
      rb = 16'($urandom);
      run_op("random", sel ? 1 : 4, rb, xs, ws, int'($urandom_range(60)), 1'b0, 16'h0000,
             1'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
